// File: rtl/traffic_phase_fsm_pkg.sv
// Shared phase encoding, lamp constants and decode helpers for the traffic
// phase sequencer.
package traffic_phase_fsm_pkg;

    typedef enum logic [2:0] {
        INIT_RED = 3'd0,
        A_GREEN  = 3'd1,
        A_YELLOW = 3'd2,
        AR_AB    = 3'd3,
        B_GREEN  = 3'd4,
        B_YELLOW = 3'd5,
        AR_BA    = 3'd6
    } phase_t;

    // Lamp encoding is {R,Y,G}, one-hot.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Returns {light_a, light_b} for a phase; every non-green/yellow phase is all-red.
    function automatic logic [5:0] lamps(input phase_t p);
        logic [5:0] l;
        l = {RED, RED};
        case (p)
            A_GREEN:  l = {GRN, RED};
            A_YELLOW: l = {YEL, RED};
            B_GREEN:  l = {RED, GRN};
            B_YELLOW: l = {RED, YEL};
            default:  l = {RED, RED};
        endcase
        return l;
    endfunction

    function automatic logic is_green(input phase_t p);
        return (p == A_GREEN) || (p == B_GREEN);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level input; both flops clear on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/traffic_phase_fsm.sv
// Sequences roads A and B through green, yellow and all-red phases, arbitrating
// on the priority level and synchronised vehicle sensors with enforced timings.
module traffic_phase_fsm
    import traffic_phase_fsm_pkg::*;
#(
    parameter int GREEN_MIN   = 8,
    parameter int GREEN_MAX   = 32,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prio,        // priority level: 0 = road A preferred, 1 = road B
    input  logic       sensor_a,
    input  logic       sensor_b,
    output logic [2:0] light_a,
    output logic [2:0] light_b,
    output logic [2:0] phase,
    output logic       green_start
);

    localparam int TW = $clog2(GREEN_MAX + 1);

    localparam logic [TW-1:0] T_MIN = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_MAX = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] T_YEL = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] T_AR  = TW'(ALLRED_TIME - 1);

    phase_t        state;
    phase_t        state_nxt;
    logic [TW-1:0] timer;
    logic          sa_s;
    logic          sb_s;
    logic          a_swap;
    logic          b_swap;

    sync_2ff u_sync_a (
        .clk (clk),
        .rst (rst),
        .d   (sensor_a),
        .q   (sa_s)
    );

    sync_2ff u_sync_b (
        .clk (clk),
        .rst (rst),
        .d   (sensor_b),
        .q   (sb_s)
    );

    // A green is only released once min green is served and someone else has a claim.
    assign a_swap = (timer >= T_MIN) &&
                    (prio || (sb_s && !sa_s) || (sb_s && (timer == T_MAX)));
    assign b_swap = (timer >= T_MIN) &&
                    (!prio || (sa_s && !sb_s) || (sa_s && (timer == T_MAX)));

    always_comb begin
        state_nxt = state;
        case (state)
            INIT_RED: if (timer == T_AR)  state_nxt = prio ? B_GREEN : A_GREEN;
            A_GREEN:  if (a_swap)         state_nxt = A_YELLOW;
            A_YELLOW: if (timer == T_YEL) state_nxt = AR_AB;
            AR_AB:    if (timer == T_AR)  state_nxt = B_GREEN;
            B_GREEN:  if (b_swap)         state_nxt = B_YELLOW;
            B_YELLOW: if (timer == T_YEL) state_nxt = AR_BA;
            AR_BA:    if (timer == T_AR)  state_nxt = A_GREEN;
            default:                      state_nxt = INIT_RED;
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT_RED;
            timer       <= '0;
            light_a     <= RED;
            light_b     <= RED;
            green_start <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                timer <= '0;
            end else if (timer != T_MAX) begin
                timer <= timer + TW'(1);
            end
            {light_a, light_b} <= lamps(state_nxt);
            green_start        <= (state_nxt != state) && is_green(state_nxt);
        end
    end

    assign phase = state;

endmodule
